// File: rtl/apb_pid_csr.sv
// APB4 completer holding the PID accelerator control/status registers.
// Transfers advance only on PCLKEN-qualified HCLK edges, with a programmable wait-state count.
module apb_pid_csr #(
    parameter int ADDRWIDTH   = 12,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                 HCLK,
    input  logic                 HRESETn,
    input  logic                 PCLKEN,
    input  logic                 PSEL,
    input  logic [ADDRWIDTH-1:0] PADDR,
    input  logic                 PENABLE,
    input  logic                 PWRITE,
    input  logic [31:0]          PWDATA,
    input  logic [3:0]           PSTRB,
    input  logic [2:0]           PPROT,
    output logic [31:0]          PRDATA,
    output logic                 PREADY,
    output logic                 PSLVERR,
    output logic                 pid_enable,
    output logic [31:0]          kp,
    output logic [31:0]          ki,
    output logic [31:0]          kd,
    output logic [31:0]          setpoint,
    output logic                 soft_clear,
    output logic                 irq,
    input  logic [31:0]          pid_out,
    input  logic                 pid_busy,
    input  logic                 sat_event
);

    localparam logic [2:0] LP_WAIT = WAIT_CYCLES[2:0];

    typedef enum logic {
        IDLE,
        ACCESS
    } state_t;

    state_t      r_state;
    logic [2:0]  r_addr;
    logic        r_oor;
    logic        r_write;
    logic [3:0]  r_strb;
    logic [31:0] r_wdata;
    logic        r_priv;
    logic [2:0]  r_cnt;
    logic [31:0] r_outSnap;

    logic        r_enable;
    logic        r_irqEn;
    logic        r_satSticky;
    logic        r_softClear;
    logic [31:0] r_kp;
    logic [31:0] r_ki;
    logic [31:0] r_kd;
    logic [31:0] r_setpoint;

    logic        w_ready;
    logic        w_err;
    logic        w_done;
    logic        w_commit;
    logic        w_intClr;
    logic        w_softClr;
    logic [31:0] w_rdMux;
    logic        w_unused;

    assign w_unused = ^{PPROT[2:1], PADDR[1:0]};

    assign w_ready = (r_state == ACCESS) && (r_cnt == 3'd0);

    // Illegal: outside the 8-word window, writes to read-only words, or unprivileged writes to control words.
    assign w_err = r_oor
                 | (r_write & ((r_addr == 3'd5) | (r_addr == 3'd6)))
                 | (r_write & (r_addr <= 3'd4) & ~r_priv);

    assign w_done    = PCLKEN & (r_state == ACCESS) & PSEL & PENABLE & w_ready;
    assign w_commit  = w_done & r_write & ~w_err;
    assign w_intClr  = w_commit & (r_addr == 3'd7) & r_strb[0] & r_wdata[0];
    assign w_softClr = w_commit & (r_addr == 3'd0) & r_strb[1] & r_wdata[8];

    function automatic logic [31:0] mergeBytes(input logic [31:0] oldVal,
                                               input logic [31:0] newVal,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        res = oldVal;
        for (int n = 0; n < 4; n++) begin
            if (strb[n]) res[8*n +: 8] = newVal[8*n +: 8];
        end
        return res;
    endfunction

    always_comb begin
        w_rdMux = '0;
        case (r_addr)
            3'd0:    w_rdMux = {30'd0, r_irqEn, r_enable};
            3'd1:    w_rdMux = r_kp;
            3'd2:    w_rdMux = r_ki;
            3'd3:    w_rdMux = r_kd;
            3'd4:    w_rdMux = r_setpoint;
            3'd5:    w_rdMux = {30'd0, r_satSticky, pid_busy};
            3'd6:    w_rdMux = r_outSnap;
            default: w_rdMux = {31'd0, r_satSticky};
        endcase
    end

    assign PREADY  = w_ready;
    assign PSLVERR = w_ready & w_err;
    assign PRDATA  = (w_ready && !r_write && !w_err) ? w_rdMux : 32'd0;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state   <= IDLE;
            r_addr    <= '0;
            r_oor     <= 1'b0;
            r_write   <= 1'b0;
            r_strb    <= '0;
            r_wdata   <= '0;
            r_priv    <= 1'b0;
            r_cnt     <= '0;
            r_outSnap <= '0;
        end else if (PCLKEN) begin
            case (r_state)
                IDLE: begin
                    if (PSEL && !PENABLE) begin
                        r_state   <= ACCESS;
                        r_addr    <= PADDR[4:2];
                        r_oor     <= |PADDR[ADDRWIDTH-1:5];
                        r_write   <= PWRITE;
                        r_strb    <= PSTRB;
                        r_wdata   <= PWDATA;
                        r_priv    <= PPROT[0];
                        r_cnt     <= LP_WAIT;
                        r_outSnap <= pid_out;
                    end
                end
                default: begin
                    if (!PSEL) begin
                        r_state <= IDLE;
                    end else if (r_cnt != 3'd0) begin
                        r_cnt <= r_cnt - 3'd1;
                    end else if (PENABLE) begin
                        r_state <= IDLE;
                    end
                end
            endcase
        end
    end

    // A saturation event arriving on the same edge as an INTCLR write keeps the sticky bit set.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_enable    <= 1'b0;
            r_irqEn     <= 1'b0;
            r_satSticky <= 1'b0;
            r_softClear <= 1'b0;
            r_kp        <= '0;
            r_ki        <= '0;
            r_kd        <= '0;
            r_setpoint  <= '0;
        end else begin
            r_softClear <= w_softClr;
            if (sat_event) begin
                r_satSticky <= 1'b1;
            end else if (w_intClr) begin
                r_satSticky <= 1'b0;
            end
            if (w_commit) begin
                case (r_addr)
                    3'd0: begin
                        if (r_strb[0]) begin
                            r_enable <= r_wdata[0];
                            r_irqEn  <= r_wdata[1];
                        end
                    end
                    3'd1:    r_kp       <= mergeBytes(r_kp, r_wdata, r_strb);
                    3'd2:    r_ki       <= mergeBytes(r_ki, r_wdata, r_strb);
                    3'd3:    r_kd       <= mergeBytes(r_kd, r_wdata, r_strb);
                    3'd4:    r_setpoint <= mergeBytes(r_setpoint, r_wdata, r_strb);
                    default: ;
                endcase
            end
        end
    end

    assign pid_enable = r_enable;
    assign kp         = r_kp;
    assign ki         = r_ki;
    assign kd         = r_kd;
    assign setpoint   = r_setpoint;
    assign soft_clear = r_softClear;
    assign irq        = r_satSticky & r_irqEn;

endmodule

// File: tb/tb_apb_pid_csr.sv
// Randomised scoreboard bench for apb_pid_csr: a driver queues expected responses,
// a monitor pops them on every completing APB access; a word-level model tracks register contents.
module tb_apb_pid_csr;

    localparam int WAIT = 2;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic        PCLKEN = 1'b1;
    logic        PSEL = 1'b0;
    logic [11:0] PADDR = '0;
    logic        PENABLE = 1'b0;
    logic        PWRITE = 1'b0;
    logic [31:0] PWDATA = '0;
    logic [3:0]  PSTRB = '0;
    logic [2:0]  PPROT = '0;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;
    logic        pid_enable;
    logic [31:0] kp, ki, kd, setpoint;
    logic        soft_clear;
    logic        irq;
    logic [31:0] pid_out = '0;
    logic        pid_busy = 1'b0;
    logic        sat_event = 1'b0;

    apb_pid_csr #(.ADDRWIDTH(12), .WAIT_CYCLES(WAIT)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .PCLKEN(PCLKEN), .PSEL(PSEL), .PADDR(PADDR),
        .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA), .PSTRB(PSTRB), .PPROT(PPROT),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR), .pid_enable(pid_enable),
        .kp(kp), .ki(ki), .kd(kd), .setpoint(setpoint), .soft_clear(soft_clear), .irq(irq),
        .pid_out(pid_out), .pid_busy(pid_busy), .sat_event(sat_event)
    );

    always #5 HCLK = ~HCLK;

    int          total = 0;
    int          bad = 0;
    bit          toggleMode = 1'b0;
    logic [32:0] expQ[$];
    logic [32:0] monExp;

    logic [31:0] mRegs[0:7];
    logic        mEn = 1'b0;
    logic        mIrqEn = 1'b0;
    logic        mSat = 1'b0;
    int          softExp = 0;
    int          softSeen = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge HCLK) begin
        if (HRESETn && soft_clear) softSeen++;
        if (HRESETn && PSEL && PENABLE && PREADY && PCLKEN) begin
            if (expQ.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpected_completion: got addr %h expected none", PADDR);
            end else begin
                monExp = expQ.pop_front();
                checkOutput("pslverr", {31'd0, PSLVERR}, {31'd0, monExp[32]});
                checkOutput("prdata", PRDATA, monExp[31:0]);
            end
        end
    end

    function automatic logic [31:0] modelRead(input logic [2:0] idx);
        case (idx)
            3'd0:                   return {30'd0, mIrqEn, mEn};
            3'd1, 3'd2, 3'd3, 3'd4: return mRegs[idx];
            3'd5:                   return {30'd0, mSat, pid_busy};
            3'd6:                   return pid_out;
            default:                return {31'd0, mSat};
        endcase
    endfunction

    task automatic step(output bit en);
        en = PCLKEN;
        @(posedge HCLK);
        #1;
        PCLKEN = toggleMode ? ~PCLKEN : 1'b1;
    endtask

    task automatic applyStimulus(input logic [11:0] a, input bit w, input logic [31:0] d,
                                 input logic [3:0] s, input logic [2:0] p,
                                 input int abortAt, input bit satAtEnd);
        bit          en;
        bit          done;
        bit          err;
        int          waits;
        int          hclks;
        int          guard;
        logic [2:0]  idx;
        logic [31:0] rd;
        idx = a[4:2];
        err = (a[11:5] != 7'd0) || (w && (idx == 3'd5 || idx == 3'd6)) || (w && idx <= 3'd4 && !p[0]);
        rd  = (!w && !err) ? modelRead(idx) : 32'd0;
        if (abortAt < 0) expQ.push_back({err, rd});
        PADDR = a; PWRITE = w; PWDATA = d; PSTRB = s; PPROT = p; PSEL = 1'b1; PENABLE = 1'b0;
        guard = 0;
        do begin
            step(en);
            guard++;
        end while (!en && guard < 10);
        PENABLE = 1'b1;
        waits = 0; hclks = 0; guard = 0; done = 1'b0;
        while (!done && guard < 200) begin
            guard++;
            if (PCLKEN && abortAt >= 0 && waits == abortAt) begin
                PSEL = 1'b0;
                PENABLE = 1'b0;
                step(en);
                done = 1'b1;
            end else begin
                if (PCLKEN && PREADY) begin
                    if (satAtEnd) sat_event = 1'b1;
                    done = 1'b1;
                end else if (PCLKEN) begin
                    waits++;
                end
                step(en);
                hclks++;
                sat_event = 1'b0;
            end
        end
        PSEL = 1'b0;
        PENABLE = 1'b0;
        if (!done) begin
            total++;
            bad++;
            $display("[TB] FAIL timeout: got no PREADY expected completion at addr %h", a);
        end
        if (abortAt < 0) begin
            checkOutput("wait_states", waits, WAIT);
            if (toggleMode) checkOutput("stretched_hclks", hclks, 2 * (WAIT + 1));
            if (w && !err) begin
                if (idx == 3'd0 && s[0]) begin
                    mEn = d[0];
                    mIrqEn = d[1];
                end
                if (idx == 3'd0 && s[1] && d[8]) softExp++;
                if (idx >= 3'd1 && idx <= 3'd4) begin
                    for (int n = 0; n < 4; n++) begin
                        if (s[n]) mRegs[idx][8*n +: 8] = d[8*n +: 8];
                    end
                end
                if (idx == 3'd7 && s[0] && d[0]) mSat = 1'b0;
            end
            if (satAtEnd) mSat = 1'b1;
        end
    endtask

    task automatic checkModel();
        bit en;
        step(en);
        checkOutput("kp", kp, mRegs[1]);
        checkOutput("ki", ki, mRegs[2]);
        checkOutput("kd", kd, mRegs[3]);
        checkOutput("setpoint", setpoint, mRegs[4]);
        checkOutput("pid_enable", {31'd0, pid_enable}, {31'd0, mEn});
        checkOutput("irq", {31'd0, irq}, {31'd0, mSat & mIrqEn});
        checkOutput("soft_clear_count", softSeen, softExp);
    endtask

    initial begin
        bit          en;
        logic [11:0] a;
        for (int i = 0; i < 8; i++) mRegs[i] = '0;

        repeat (3) @(posedge HCLK);
        #1;
        checkOutput("rst_prdata", PRDATA, 32'd0);
        checkOutput("rst_pready", {31'd0, PREADY}, 32'd0);
        checkOutput("rst_pslverr", {31'd0, PSLVERR}, 32'd0);
        checkOutput("rst_soft_clear", {31'd0, soft_clear}, 32'd0);
        checkOutput("rst_irq", {31'd0, irq}, 32'd0);
        checkOutput("rst_kp", kp, 32'd0);
        HRESETn = 1'b1;
        step(en);

        $display("[TB] reset read sweep");
        for (int i = 0; i < 8; i++) begin
            applyStimulus(12'(i * 4), 1'b0, 32'd0, 4'h0, 3'b001, -1, 1'b0);
            checkOutput("idle_pready", {31'd0, PREADY}, 32'd0);
        end
        checkModel();

        $display("[TB] gains and byte lanes");
        applyStimulus(12'h004, 1'b1, 32'h12345678, 4'hF, 3'b001, -1, 1'b0);
        checkModel();
        checkOutput("kp_direct", kp, 32'h12345678);
        applyStimulus(12'h004, 1'b0, 32'd0, 4'h0, 3'b001, -1, 1'b0);
        applyStimulus(12'h008, 1'b1, 32'hFFFFFFFF, 4'hF, 3'b001, -1, 1'b0);
        applyStimulus(12'h008, 1'b1, 32'h00AB0000, 4'b0100, 3'b001, -1, 1'b0);
        checkModel();
        checkOutput("ki_direct", ki, 32'hFFABFFFF);
        applyStimulus(12'h010, 1'b1, 32'hDEADBEEF, 4'h0, 3'b001, -1, 1'b0);
        checkModel();

        $display("[TB] error cases");
        applyStimulus(12'h00C, 1'b1, 32'hCAFEF00D, 4'hF, 3'b001, -1, 1'b0);
        applyStimulus(12'h020, 1'b0, 32'd0, 4'h0, 3'b001, -1, 1'b0);
        applyStimulus(12'h020, 1'b1, 32'h1, 4'hF, 3'b001, -1, 1'b0);
        applyStimulus(12'h014, 1'b1, 32'h3, 4'hF, 3'b001, -1, 1'b0);
        applyStimulus(12'h018, 1'b1, 32'h3, 4'hF, 3'b001, -1, 1'b0);
        applyStimulus(12'h00C, 1'b1, 32'h11111111, 4'hF, 3'b000, -1, 1'b0);
        checkModel();
        checkOutput("kd_direct", kd, 32'hCAFEF00D);

        $display("[TB] saturation and interrupt");
        applyStimulus(12'h000, 1'b1, 32'h2, 4'hF, 3'b001, -1, 1'b0);
        sat_event = 1'b1;
        step(en);
        sat_event = 1'b0;
        mSat = 1'b1;
        checkModel();
        checkOutput("irq_direct", {31'd0, irq}, 32'd1);
        applyStimulus(12'h014, 1'b0, 32'd0, 4'h0, 3'b001, -1, 1'b0);
        applyStimulus(12'h01C, 1'b1, 32'h1, 4'h1, 3'b001, -1, 1'b1);
        checkModel();
        applyStimulus(12'h01C, 1'b1, 32'h1, 4'h1, 3'b001, -1, 1'b0);
        checkModel();
        checkOutput("irq_cleared", {31'd0, irq}, 32'd0);

        $display("[TB] stretched PCLKEN and abort");
        toggleMode = 1'b1;
        applyStimulus(12'h000, 1'b1, 32'h101, 4'hF, 3'b001, -1, 1'b0);
        checkModel();
        checkOutput("pid_enable_direct", {31'd0, pid_enable}, 32'd1);
        applyStimulus(12'h000, 1'b1, 32'h100, 4'hF, 3'b001, 1, 1'b0);
        checkModel();
        toggleMode = 1'b0;
        step(en);
        step(en);

        $display("[TB] random traffic");
        for (int t = 0; t < 80; t++) begin
            pid_out  = $urandom;
            pid_busy = 1'($urandom_range(0, 1));
            a = 12'($urandom_range(0, 31));
            if ($urandom_range(0, 7) == 0) a[11:5] = 7'($urandom_range(1, 127));
            applyStimulus(a, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)),
                          3'($urandom_range(0, 7)), -1, 1'($urandom_range(0, 9) == 0));
            if (t % 8 == 7) checkModel();
        end
        checkModel();

        checkOutput("queue_drained", expQ.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/apb_pid_csr.md
Name: apb_pid_csr

Overview:
APB4 completer (slave) holding the PID accelerator control/status registers. It sits on the APB side of the AHB-to-APB bridge and shares the bridge's HCLK and PCLKEN. It provides programmable PCLKEN-qualified wait states, PSTRB byte-lane writes, and PSLVERR for illegal accesses. It drives gains and setpoint to the PID core and collects status and saturation events from it.

Parameters:
ADDRWIDTH, 12, PADDR width; only PADDR[4:2] are decoded, PADDR[ADDRWIDTH-1:5]!=0 is out of range.
WAIT_CYCLES, 1, number of PCLKEN-qualified access cycles with PREADY=0 before completion; legal range 0..7.

Ports:
HCLK  in  1  clock.
HRESETn  in  1  reset.
PCLKEN  in  1  APB clock enable; the APB state only advances on HCLK edges with PCLKEN=1.
PSEL  in  1  select.
PADDR  in  ADDRWIDTH  byte address.
PENABLE  in  1  access phase.
PWRITE  in  1  1=write.
PWDATA  in  32  write data.
PSTRB  in  4  write byte lanes.
PPROT  in  3  protection; bit0=privileged.
PRDATA  out  32  read data.
PREADY  out  1  transfer complete.
PSLVERR  out  1  error, valid only while PREADY=1.
pid_enable  out  1  CTRL[0].
kp, ki, kd  out  32 each  gain registers.
setpoint  out  32  setpoint register.
soft_clear  out  1  one-HCLK pulse.
irq  out  1  interrupt level.
pid_out  in  32  core output.
pid_busy  in  1  core busy.
sat_event  in  1  saturation pulse, 1 HCLK.

Behaviour:
- Reset: HRESETn is asynchronous and active-low; the clock is HCLK.
- Reset values: all registers 0. PRDATA=0, PREADY=0, PSLVERR=0, soft_clear=0, irq=0.
- Register map (word offsets):
  - 0x00 CTRL RW: [0] enable, [1] irq_en. Writing bit8=1 pulses soft_clear; bit8 reads 0. Other bits read 0.
  - 0x04 KP RW; 0x08 KI RW; 0x0C KD RW; 0x10 SETPOINT RW.
  - 0x14 STATUS RO: [0] pid_busy, [1] sat_sticky.
  - 0x18 OUT RO: snapshot of pid_out.
  - 0x1C INTCLR: reads {31'b0, sat_sticky}; writing 1 to bit0 with PSTRB[0]=1 clears sat_sticky.
- FSM states: IDLE, ACCESS.
- IDLE to ACCESS: on an HCLK edge with PCLKEN & PSEL & ~PENABLE (setup phase). At that edge:
  - latch the address, PWRITE, PSTRB, PWDATA and PPROT;
  - load wait counter = WAIT_CYCLES;
  - snapshot pid_out for OUT.
- ACCESS:
  - PREADY = (counter==0), combinational from registered state.
  - On each PCLKEN=1 edge with counter!=0, decrement the counter.
  - On the PCLKEN=1 edge with PSEL & PENABLE & PREADY: commit the write if there is no error, then return to IDLE.
  - A PCLKEN=0 edge changes nothing.
- PSEL=0 seen on a PCLKEN=1 edge in ACCESS (abort): go to IDLE with no commit and no soft_clear.
- PRDATA: the latched-address register value while PREADY=1 and the access is a read; 0 otherwise.
- PSLVERR=1 (only with PREADY=1) for any of:
  - address out of range;
  - write to 0x14 or 0x18;
  - write to 0x00–0x10 with PPROT[0]=0.
  An errored access writes nothing and returns PRDATA=0.
- Byte writes: register byte n updates only if PSTRB[n]=1. A write with PSTRB=0 completes OKAY with no effect.
- soft_clear: asserted for exactly the one HCLK cycle following the commit edge.
- sat_sticky: set by sat_event, cleared by INTCLR. A set and a clear on the same edge: set wins.
- irq = sat_sticky & irq_en (registered values).
- WAIT_CYCLES=0: PREADY=1 in the first access cycle, so the minimum transfer is setup plus one access PCLK.
- Back-to-back transfers: each needs a new setup phase; no pipelining.
- Reset mid-transfer: immediate return to IDLE with PREADY=0; registers take reset values.

Test Plan:
1. Reset, PCLKEN=1 constantly, read every offset -> all read 0x0; PREADY=0 between transfers.
2. WAIT_CYCLES=2, privileged write KP=0x12345678 -> PREADY low for 2 access cycles, high on the 3rd, PSLVERR=0; kp=0x12345678 the cycle after the commit; read-back matches.
3. Write KI=0xFFFFFFFF, then write 0x00AB0000 with PSTRB=4'b0100 -> ki=0xFFABFFFF.
4. Each error case -> PSLVERR=1 with PREADY=1 and the target unchanged:
   - address 0x20;
   - write STATUS;
   - write KD with PPROT=3'b000.
5. CTRL=0x2 then sat_event pulse -> irq=1 and STATUS=0x2. INTCLR write 0x1 on the same edge as a new sat_event -> sat_sticky stays 1. A later clear alone -> irq=0.
6. PCLKEN toggling every other cycle, CTRL write 0x101 -> transfer timing stretches 2x; pid_enable=1; soft_clear is high exactly 1 HCLK. The same write aborted by dropping PSEL mid-access -> no change.
